lfsr_prng_stream: RTL

- Parametrised Galois-free (Fibonacci, XNOR-feedback) LFSR pseudo-random generator for the MAC datapath test/masking sources.
- Successor to the fixed 6-bit single-step LFSR. Adds generic width, tap mask, and multiple steps per cycle.
- Adds a run-time seed load, a warm-up discard phase, and a valid/ready output stream.
- Feeds randomness consumers that may stall.

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_unroll.sv | 23 ++
 rtl/lfsr_prng_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: state enum, all-ones lockup constant generator,
// single-step XNOR Fibonacci advance and default maximal-length tap masks.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 64;

  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } lfsr_state_t;

  localparam logic [5:0]  LFSR_TAPS_6  = 6'b110000;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'b1011_1000;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // All-ones value of the given width; the XNOR-feedback fixed point.
  function automatic lfsr_word_t LFSR_LOCKUP_XNOR(input int unsigned width);
    return {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
  endfunction

  function automatic lfsr_word_t lfsr_step(input lfsr_word_t state,
                                           input lfsr_word_t taps,
                                           input int unsigned width);
    logic fb;
    fb = ~^(state & taps);
    return ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & LFSR_LOCKUP_XNOR(width);
  endfunction

endpackage

// File: rtl/lfsr_unroll.sv
// Combinational unroll of STAGES chained single LFSR steps.
module lfsr_unroll
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH  = 6,
  parameter logic [WIDTH-1:0]  TAPS   = 6'b110000,
  parameter int unsigned       STAGES = 1
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);

  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = state_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_step
    assign chain[i+1] = WIDTH'(lfsr_step(lfsr_word_t'(chain[i]), lfsr_word_t'(TAPS), WIDTH));
  end

  assign state_out = chain[STAGES];

endmodule

// File: rtl/lfsr_prng_stream.sv
// XNOR Fibonacci LFSR random stream with seed load, warm-up discard and
// valid/ready output. Optional macro LFSR_LOCKUP_RECOVER_EN adds all-ones recovery.
module lfsr_prng_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH  = 6,
  parameter logic [WIDTH-1:0]  TAPS   = 6'b110000,
  parameter int unsigned       OUT_W  = 1,
  parameter int unsigned       WARMUP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             lockup
);

  if (WIDTH < 2 || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_prng_stream: WIDTH must be in 2..64");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_prng_stream: OUT_W must be in 1..WIDTH");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("lfsr_prng_stream: TAPS must not be zero");
  end
  if (WARMUP > 255) begin : g_bad_warmup
    $error("lfsr_prng_stream: WARMUP must be in 0..255");
  end

  localparam logic [WIDTH-1:0] LOCKUP_VAL = WIDTH'(LFSR_LOCKUP_XNOR(WIDTH));
  localparam logic [7:0]       WARM_LAST  = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
  localparam bit               HAS_WARMUP = (WARMUP != 0);

  lfsr_state_t      fsm_p0;
  lfsr_state_t      fsm_d;
  logic [WIDTH-1:0] state_p0;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] adv_state;
  logic [7:0]       warm_cnt_p0;
  logic [7:0]       warm_cnt_d;
  logic             lockup_p0;
  logic             vld_p0;
  logic             fire;
  logic             recover;

  lfsr_unroll #(
    .WIDTH  (WIDTH),
    .TAPS   (TAPS),
    .STAGES (OUT_W)
  ) u_unroll (
    .state_in  (state_p0),
    .state_out (adv_state)
  );

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign recover = (state_p0 == LOCKUP_VAL);
`else
  assign recover = 1'b0;
`endif

  assign fire = vld_p0 && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_p0 <= WARM;
    end else begin
      fsm_p0 <= fsm_d;
    end
  end

  // WARM exits after WARMUP advances; with no warm-up it only inserts the
  // single bubble cycle that follows reset or a seed load.
  always_comb begin
    fsm_d = fsm_p0;
    if (seed_load) begin
      fsm_d = WARM;
    end else if (recover) begin
      fsm_d = RUN;
    end else if (fsm_p0 == WARM && warm_cnt_p0 == WARM_LAST) begin
      fsm_d = RUN;
    end
  end

  always_comb begin
    vld_p0 = (fsm_p0 == RUN) && !recover;
  end

  always_comb begin
    state_d    = state_p0;
    warm_cnt_d = warm_cnt_p0;
    if (seed_load) begin
      state_d    = seed_in;
      warm_cnt_d = 8'd0;
    end else if (recover) begin
      state_d = '0;
    end else if (fsm_p0 == WARM) begin
      if (HAS_WARMUP) begin
        state_d = adv_state;
        if (warm_cnt_p0 != 8'hFF) begin
          warm_cnt_d = warm_cnt_p0 + 8'd1;
        end
      end
    end else if (fire) begin
      state_d = adv_state;
    end
  end

  // Stage p0: state, warm-up counter and lockup status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= '0;
      warm_cnt_p0 <= 8'd0;
      lockup_p0   <= 1'b0;
    end else begin
      state_p0    <= state_d;
      warm_cnt_p0 <= warm_cnt_d;
      lockup_p0   <= (state_d == LOCKUP_VAL);
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = state_p0[OUT_W-1:0];
  assign lockup    = lockup_p0;

endmodule
